// File: rtl/timer_entry_pkg.sv
// -----------------------------------------------------------------------------
// timer_entry_pkg
//   Shared types and helpers for the microwave timer keypad entry front end.
//   - bcd_t          : one BCD digit
//   - key_state_t    : key FSM states (IDLE, PRESS, HELD, RELEASE)
//   - BCD_BLANK      : value of an empty digit position
//   - onehot_to_bcd  : index of the set bit of a one-hot key code
// -----------------------------------------------------------------------------
package timer_entry_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } key_state_t;

    localparam bcd_t BCD_BLANK = 4'h0;

    // Widest key vector the encoder accepts; narrower vectors are zero-extended.
    localparam int KEY_MAX = 16;

    // Callers only pass validated one-hot codes, so the highest set bit is the
    // only set bit.
    function automatic bcd_t onehot_to_bcd(input logic [KEY_MAX-1:0] onehot);
        bcd_t v;
        v = BCD_BLANK;
        for (int i = 0; i < KEY_MAX; i++) begin
            if (onehot[i]) v = 4'(i);
        end
        return v;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
//   Seconds timebase. Counts 0..DIV-1 while run is high and emits a one-cycle
//   tick in the cycle after the count reaches DIV-1. While run is low the count
//   is held at 0, so every run period starts a fresh full interval.
// Ports:
//   clk   in  system clock, rising edge
//   rstn  in  asynchronous active-low reset
//   run   in  1 = count, 0 = hold count at 0
//   tick  out one-cycle pulse every DIV cycles of run
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;
    logic          at_top;

    assign at_top = (count == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            // Gating with run means a period cut short by run falling never ticks.
            tick <= run && at_top;
            if (!run || at_top) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/timer_entry_ctrl.sv
// -----------------------------------------------------------------------------
// timer_entry_ctrl
//   Keypad entry and timebase front end for the microwave timer. Turns a raw
//   one-hot key vector into accepted BCD digits, shifts them into an
//   NDIGITS-deep entry buffer and produces the seconds tick in run mode.
//
// Build option:
//   KEY_DEBOUNCE_EN  defined   : PRESS and RELEASE need DEB_CYCLES stable samples
//                    undefined : accept on the registered key edge, release on
//                                the first key==0 sample
// Ports:
//   clk      in   system clock, rising edge
//   rstn     in   asynchronous active-low reset
//   enablen  in   0 = entry mode (keys live), 1 = run mode (tick live)
//   clr      in   synchronous clear of the entry buffer
//   key      in   raw keys, active high, key[i] = digit i
//   d        out  last accepted digit (BCD)
//   loadn    out  active-low one-cycle strobe per stored digit
//   digits   out  entry buffer, [3:0] = newest digit
//   ndig     out  number of valid digits, saturates at NDIGITS
//   full     out  ndig == NDIGITS
//   pgt_1hz  out  one-cycle seconds tick, run mode only
// -----------------------------------------------------------------------------
module timer_entry_ctrl
    import timer_entry_pkg::*;
#(
    parameter int NKEYS      = 10,
    parameter int NDIGITS    = 4,
    parameter int DIV        = 100,
    parameter int DEB_CYCLES = 4,
    parameter int OVERWRITE  = 0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           enablen,
    input  logic                           clr,
    input  logic [NKEYS-1:0]               key,
    output logic [3:0]                     d,
    output logic                           loadn,
    output logic [4*NDIGITS-1:0]           digits,
    output logic [$clog2(NDIGITS+1)-1:0]   ndig,
    output logic                           full,
    output logic                           pgt_1hz
);

    localparam int DIG_W  = 4 * NDIGITS;
    localparam int NDIG_W = $clog2(NDIGITS + 1);

    key_state_t       state;
    logic [NKEYS-1:0] first_key;
    logic             key_nz;
    logic             key_multi;
    logic             stable_done;
    logic             accept;
    logic             store;
    bcd_t             enc;

    assign key_nz    = |key;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign key_multi = |(key & (key - NKEYS'(1)));
    assign enc       = onehot_to_bcd(KEY_MAX'(first_key));
    assign full      = (ndig == NDIG_W'(NDIGITS));

`ifdef KEY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 2);

    // Number of consecutive stable samples seen so far in PRESS/RELEASE. The
    // sample that caused entry (taken in IDLE or HELD) already counts as one.
    logic [CNT_W-1:0] stab_cnt;

    assign stable_done = (stab_cnt >= CNT_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stab_cnt <= '0;
        end else if (state == IDLE || state == HELD) begin
            stab_cnt <= CNT_W'(1);
        end else if (!stable_done) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
        end
    end
`else
    // Without debounce every legal configuration finishes PRESS and RELEASE
    // after a single sample.
    assign stable_done = (DEB_CYCLES >= 1);
`endif

    // A press completes when the captured code is still present and stable.
    assign accept = !enablen && (state == PRESS) && (key == first_key) && stable_done;
    // clr beats a simultaneous accept; a full buffer swallows the press unless
    // overwriting is allowed.
    assign store  = accept && !clr && (!full || (OVERWRITE != 0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            first_key <= '0;
            d         <= BCD_BLANK;
            loadn     <= 1'b1;
            digits    <= '0;
            ndig      <= '0;
        end else begin
            loadn <= 1'b1;

            if (enablen) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (key_nz) begin
                            // Chords are never accepted; wait for full release.
                            if (key_multi) begin
                                state <= HELD;
                            end else begin
                                state     <= PRESS;
                                first_key <= key;
                            end
                        end
                    end
                    PRESS: begin
                        if (key != first_key) begin
                            state <= IDLE;
                        end else if (stable_done) begin
                            state <= HELD;
                        end
                    end
                    HELD: begin
                        if (!key_nz) state <= RELEASE;
                    end
                    RELEASE: begin
                        if (key_nz) begin
                            state <= HELD;
                        end else if (stable_done) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (clr) begin
                digits <= '0;
                ndig   <= '0;
            end else if (store) begin
                loadn  <= 1'b0;
                d      <= enc;
                // Shifting left drops the oldest digit when the buffer is full.
                digits <= (digits << 4) | DIG_W'(enc);
                if (!full) ndig <= ndig + NDIG_W'(1);
            end
        end
    end

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rstn (rstn),
        .run  (enablen),
        .tick (pgt_1hz)
    );

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_entry_ctrl
//   Drives two copies of timer_entry_ctrl (OVERWRITE=0 and OVERWRITE=1) with
//   the same keys and compares them against a digit-queue reference model.
// -----------------------------------------------------------------------------
module tb_timer_entry_ctrl;

    localparam int NKEYS   = 10;
    localparam int NDIGITS = 4;
    localparam int DIV     = 100;
    localparam int DEB     = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int LAT = (DEB > 2) ? DEB : 2;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic             enablen;
    logic             clr;
    logic [NKEYS-1:0] key;

    logic [3:0]  d0, d1;
    logic        loadn0, loadn1;
    logic [15:0] digits0, digits1;
    logic [2:0]  ndig0, ndig1;
    logic        full0, full1;
    logic        tick0, tick1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: digits in arrival order (oldest first) and last loaded digit.
    int q0[$];
    int q1[$];
    int dm0 = 0;
    int dm1 = 0;

    always #5 clk = ~clk;

    timer_entry_ctrl #(
        .NKEYS(NKEYS), .NDIGITS(NDIGITS), .DIV(DIV), .DEB_CYCLES(DEB), .OVERWRITE(0)
    ) dut0 (
        .clk(clk), .rstn(rstn), .enablen(enablen), .clr(clr), .key(key),
        .d(d0), .loadn(loadn0), .digits(digits0), .ndig(ndig0), .full(full0),
        .pgt_1hz(tick0)
    );

    timer_entry_ctrl #(
        .NKEYS(NKEYS), .NDIGITS(NDIGITS), .DIV(DIV), .DEB_CYCLES(DEB), .OVERWRITE(1)
    ) dut1 (
        .clk(clk), .rstn(rstn), .enablen(enablen), .clr(clr), .key(key),
        .d(d1), .loadn(loadn1), .digits(digits1), .ndig(ndig1), .full(full1),
        .pgt_1hz(tick1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_digits(input int which);
        logic [15:0] v;
        v = 16'h0;
        if (which == 0) begin
            foreach (q0[i]) v = {v[11:0], 4'(q0[i])};
        end else begin
            foreach (q1[i]) v = {v[11:0], 4'(q1[i])};
        end
        return v;
    endfunction

    task automatic check_state(input string tag, input logic el0, input logic el1, input logic etick);
        check({tag, "_loadn0"},  64'(loadn0),  64'(el0));
        check({tag, "_d0"},      64'(d0),      64'(dm0));
        check({tag, "_digits0"}, 64'(digits0), 64'(exp_digits(0)));
        check({tag, "_ndig0"},   64'(ndig0),   64'(q0.size()));
        check({tag, "_full0"},   64'(full0),   64'(q0.size() == NDIGITS));
        check({tag, "_tick0"},   64'(tick0),   64'(etick));
        check({tag, "_loadn1"},  64'(loadn1),  64'(el1));
        check({tag, "_d1"},      64'(d1),      64'(dm1));
        check({tag, "_digits1"}, 64'(digits1), 64'(exp_digits(1)));
        check({tag, "_ndig1"},   64'(ndig1),   64'(q1.size()));
        check({tag, "_full1"},   64'(full1),   64'(q1.size() == NDIGITS));
        check({tag, "_tick1"},   64'(tick1),   64'(etick));
    endtask

    // Hold mask for 'hold' cycles (clr pulsed before cycle clr_at, 0 = never),
    // then release for 'rel' cycles. A valid press is accepted once it has been
    // sampled stable LAT times; the strobe shows in the following cycle.
    task automatic press(input logic [NKEYS-1:0] mask, input int hold, input int clr_at, input int rel);
        bit   valid;
        int   dig;
        logic l0, l1;
        valid = $onehot(mask);
        dig   = 0;
        for (int i = 0; i < NKEYS; i++) if (mask[i]) dig = i;
        key = mask;
        for (int k = 1; k <= hold; k++) begin
            clr = (k == clr_at);
            @(posedge clk); #1;
            clr = 1'b0;
            l0 = 1'b1;
            l1 = 1'b1;
            if (k == clr_at) begin
                q0.delete();
                q1.delete();
            end else if (k == LAT && valid) begin
                if (q0.size() < NDIGITS) begin
                    q0.push_back(dig);
                    dm0 = dig;
                    l0  = 1'b0;
                end
                if (q1.size() == NDIGITS) void'(q1.pop_front());
                q1.push_back(dig);
                dm1 = dig;
                l1  = 1'b0;
            end
            check_state("press", l0, l1, 1'b0);
        end
        key = '0;
        for (int k = 1; k <= rel; k++) begin
            @(posedge clk); #1;
            check_state("release", 1'b1, 1'b1, 1'b0);
        end
    endtask

    // Run mode for n cycles: ticks expected every DIV cycles, keys ignored.
    task automatic run_mode(input int n, input bit poke);
        enablen = 1'b1;
        for (int k = 1; k <= n; k++) begin
            key = poke ? (NKEYS'(1) << $urandom_range(0, NKEYS - 1)) : '0;
            @(posedge clk); #1;
            check_state("run", 1'b1, 1'b1, (k % DIV) == 0);
        end
        key     = '0;
        enablen = 1'b0;
        @(posedge clk); #1;
        check_state("run_exit", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        q0.delete();
        q1.delete();
        check_state("clr", 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [NKEYS-1:0] mask;
        int               hold;
        int               clr_at;

        rstn    = 1'b0;
        enablen = 1'b0;
        clr     = 1'b0;
        key     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 1'b1, 1'b1, 1'b0);
        rstn = 1'b1;

        // Single press of key 3
        press(NKEYS'(1) << 3, 10, 0, LAT + 2);
        check("t1_digits0", 64'(digits0), 64'h0003);
        check("t1_ndig0",   64'(ndig0),   64'd1);
        check("t1_d0",      64'(d0),      64'd3);

        // Fill past capacity: 1,2,3,4,5
        clear_pulse();
        for (int i = 1; i <= 5; i++) press(NKEYS'(1) << i, LAT + 2, 0, LAT + 1);
        check("t2_digits0", 64'(digits0), 64'h1234);
        check("t2_full0",   64'(full0),   64'd1);
        check("t2_digits1", 64'(digits1), 64'h2345);
        check("t2_full1",   64'(full1),   64'd1);

        // Bounce 1-0-1 then stable, then an invalid chord
        clear_pulse();
        key = NKEYS'(1) << 6;
        @(posedge clk); #1;
        check_state("bounce_hi", 1'b1, 1'b1, 1'b0);
        key = '0;
        @(posedge clk); #1;
        check_state("bounce_lo", 1'b1, 1'b1, 1'b0);
        press(NKEYS'(1) << 6, LAT + 3, 0, LAT);
        check("t3_ndig0", 64'(ndig0), 64'd1);
        press(NKEYS'(10'b0000000101), LAT + 3, 0, LAT);
        check("t3_chord_ndig0", 64'(ndig0), 64'd1);

        // Run mode: ticks at 100 and 200, keys ignored; cut-short periods
        run_mode(250, 1'b1);
        run_mode(99, 1'b0);
        run_mode(150, 1'b0);

        // clr on the accept cycle, then a normal press
        press(NKEYS'(1) << 8, LAT + 2, LAT, LAT);
        check("t5_digits0", 64'(digits0), 64'h0);
        check("t5_ndig0",   64'(ndig0),   64'd0);
        press(NKEYS'(1) << 9, LAT + 2, 0, LAT);
        check("t5b_digits0", 64'(digits0), 64'h0009);

        // Asynchronous reset while the FSM is in HELD
        press(NKEYS'(1) << 7, LAT + 2, 0, 0);
        #2;
        rstn = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        dm0 = 0;
        dm1 = 0;
        check_state("async_rst", 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_state("in_rst", 1'b1, 1'b1, 1'b0);
        rstn = 1'b1;
        press(NKEYS'(1) << 5, LAT + 2, 0, LAT);
        check("t6_digits0", 64'(digits0), 64'h0005);

        // Randomized presses, chords, short holds, clears and run periods
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                mask = NKEYS'(1) << $urandom_range(0, NKEYS - 1);
            end else begin
                mask = (NKEYS'(1) << $urandom_range(0, NKEYS - 1)) |
                       (NKEYS'(1) << $urandom_range(0, NKEYS - 1));
            end
            hold   = $urandom_range(1, LAT + 4);
            clr_at = ($urandom_range(0, 9) < 2) ? $urandom_range(1, hold) : 0;
            press(mask, hold, clr_at, LAT + $urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) run_mode($urandom_range(1, 230), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
